otp_auth_core: RTL and testbench

- Parametrised one-time-password authentication engine: free-running LFSR, OTP capture, N-digit user entry, compare, attempt limiting, OTP expiry and lockout cooldown.
- Generalises the fixed 4-digit/3-attempt authenticator:
  - digit count, attempt limit and all timeouts are parameters;
  - adds a timed unlock window, a timed lockout and OTP regeneration mid-entry.
- Sits between the push-button inputs and the 7-segment display driver; drives status flags and the OTP/entry buses to the display.

---
 rtl/otp_auth_core.sv | 168 ++++++++++++++++
 tb/tb_otp_auth_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_auth_core.sv
// One-time-password authentication engine: LFSR-sourced OTP, N-digit entry,
// compare, attempt limiting, OTP expiry, timed unlock window and timed lockout.
module otp_auth_core #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned EXPIRE_CYCLES  = 50000000,
  parameter int unsigned UNLOCK_CYCLES  = 25000000,
  parameter int unsigned LOCKOUT_CYCLES = 100000000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  otp_req,
  input  logic [3:0]            digit_in,
  input  logic                  digit_strobe,
  output logic [4*DIGITS-1:0]   otp_out,
  output logic [4*DIGITS-1:0]   entry_out,
  output logic [2:0]            entry_cnt,
  output logic [3:0]            wrng_atmpt,
  output logic                  unlock,
  output logic                  lock,
  output logic                  expired,
  output logic [2:0]            state_out
);

  localparam int unsigned EW     = 4 * DIGITS;
  localparam int unsigned MAX_EU = (EXPIRE_CYCLES > UNLOCK_CYCLES) ? EXPIRE_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned MAX_C  = (MAX_EU > LOCKOUT_CYCLES) ? MAX_EU : LOCKOUT_CYCLES;
  localparam int unsigned TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_LOCKED   = 3'd4,
    S_EXPIRED  = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     lfsr;
  logic [TW-1:0]   timer, timer_nxt;
  logic            req_prev, strobe_prev;
  logic            req_rise, strobe_rise;
  logic            lfsr_fb;
  logic [EW-1:0]   otp_nxt, entry_nxt;
  logic [2:0]      cnt_nxt;
  logic [3:0]      wrng_nxt;

  assign req_rise    = otp_req & ~req_prev;
  assign strobe_rise = digit_strobe & ~strobe_prev;
  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign state_out   = state;

  // Register stage: FSM state, datapath, edge-detect history and decoded flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      timer       <= '0;
      req_prev    <= 1'b0;
      strobe_prev <= 1'b0;
      otp_out     <= '0;
      entry_out   <= '0;
      entry_cnt   <= '0;
      wrng_atmpt  <= '0;
      unlock      <= 1'b0;
      lock        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_nxt;
      lfsr        <= {lfsr[14:0], lfsr_fb};
      timer       <= timer_nxt;
      req_prev    <= otp_req;
      strobe_prev <= digit_strobe;
      otp_out     <= otp_nxt;
      entry_out   <= entry_nxt;
      entry_cnt   <= cnt_nxt;
      wrng_atmpt  <= wrng_nxt;
      unlock      <= (state_nxt == S_UNLOCKED);
      lock        <= (state_nxt == S_LOCKED);
      expired     <= (state_nxt == S_EXPIRED);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    otp_nxt   = otp_out;
    entry_nxt = entry_out;
    cnt_nxt   = entry_cnt;
    wrng_nxt  = wrng_atmpt;
    unique case (state)
      S_IDLE: begin
        if (req_rise) begin
          state_nxt = S_ENTRY;
          otp_nxt   = lfsr[EW-1:0];
          entry_nxt = '0;
          cnt_nxt   = '0;
          timer_nxt = '0;
        end
      end
      S_ENTRY: begin
        timer_nxt = timer + TW'(1);
        if (timer == TW'(EXPIRE_CYCLES - 1)) begin
          state_nxt = S_EXPIRED;
        end else if (req_rise) begin
          otp_nxt   = lfsr[EW-1:0];
          entry_nxt = '0;
          cnt_nxt   = '0;
          timer_nxt = '0;
        end else if (strobe_rise) begin
          entry_nxt = EW'({entry_out, digit_in});
          cnt_nxt   = entry_cnt + 3'd1;
          if (entry_cnt == 3'(DIGITS - 1)) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (entry_out == otp_out) begin
          state_nxt = S_UNLOCKED;
          timer_nxt = '0;
          wrng_nxt  = '0;
        end else begin
          wrng_nxt = wrng_atmpt + 4'd1;
          if (wrng_atmpt == 4'(MAX_ATTEMPTS - 1)) begin
            state_nxt = S_LOCKED;
            timer_nxt = '0;
          end else begin
            // Timer keeps running so retries cannot extend the OTP lifetime.
            state_nxt = S_ENTRY;
            entry_nxt = '0;
            cnt_nxt   = '0;
          end
        end
      end
      S_UNLOCKED: begin
        timer_nxt = timer + TW'(1);
        if (timer == TW'(UNLOCK_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          entry_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      S_LOCKED: begin
        timer_nxt = timer + TW'(1);
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          wrng_nxt  = '0;
          entry_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      S_EXPIRED: begin
        // Attempt count survives expiry so expiring cannot reset it.
        if (req_rise) begin
          state_nxt = S_ENTRY;
          otp_nxt   = lfsr[EW-1:0];
          entry_nxt = '0;
          cnt_nxt   = '0;
          timer_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_otp_auth_core.sv
// Random and directed stimulus for two otp_auth_core configurations, checked
// cycle by cycle against a deadline-based behavioural model.
module tb_otp_auth_core;

  localparam int EXP = 20;
  localparam int UNL = 8;
  localparam int LCK = 16;
  localparam int MAXA = 3;

  logic clk = 1'b0;
  logic reset, otp_req, digit_strobe;
  logic [3:0] digit_in;

  logic [15:0] a_otp, a_ent;
  logic [7:0]  b_otp, b_ent;
  logic [2:0]  a_cnt, b_cnt, a_st, b_st;
  logic [3:0]  a_wr, b_wr;
  logic        a_ul, a_lk, a_ex, b_ul, b_lk, b_ex;

  otp_auth_core #(.DIGITS(4), .MAX_ATTEMPTS(MAXA), .EXPIRE_CYCLES(EXP), .UNLOCK_CYCLES(UNL),
                  .LOCKOUT_CYCLES(LCK), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(reset), .otp_req(otp_req), .digit_in(digit_in), .digit_strobe(digit_strobe),
    .otp_out(a_otp), .entry_out(a_ent), .entry_cnt(a_cnt), .wrng_atmpt(a_wr),
    .unlock(a_ul), .lock(a_lk), .expired(a_ex), .state_out(a_st));

  otp_auth_core #(.DIGITS(2), .MAX_ATTEMPTS(MAXA), .EXPIRE_CYCLES(EXP), .UNLOCK_CYCLES(UNL),
                  .LOCKOUT_CYCLES(LCK), .LFSR_SEED(16'h0001)) dut_b (
    .clk(clk), .reset(reset), .otp_req(otp_req), .digit_in(digit_in), .digit_strobe(digit_strobe),
    .otp_out(b_otp), .entry_out(b_ent), .entry_cnt(b_cnt), .wrng_atmpt(b_wr),
    .unlock(b_ul), .lock(b_lk), .expired(b_ex), .state_out(b_st));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Behavioural model state, one slot per instance; timing tracked as absolute deadlines.
  int mst[2], mlfsr[2], motp[2], ment[2], mcnt[2], mwr[2], mdl[2], mend[2], mpreq[2], mpstb[2];

  function automatic int dig(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int seed(input int i);
    return (i == 0) ? 32'hACE1 : 32'h0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic capture(input int i, input int cur);
    motp[i] = cur & ((1 << (4 * dig(i))) - 1);
    ment[i] = 0;
    mcnt[i] = 0;
    mdl[i]  = cyc + EXP;
    mst[i]  = 1;
  endtask

  task automatic model_step(input int i);
    int cur, rr, rs;
    if (reset) begin
      mst[i] = 0; mlfsr[i] = seed(i); motp[i] = 0; ment[i] = 0; mcnt[i] = 0;
      mwr[i] = 0; mpreq[i] = 0; mpstb[i] = 0; mdl[i] = 0; mend[i] = 0;
    end else begin
      rr = (otp_req && !mpreq[i]) ? 1 : 0;
      rs = (digit_strobe && !mpstb[i]) ? 1 : 0;
      mpreq[i] = int'(otp_req);
      mpstb[i] = int'(digit_strobe);
      cur = mlfsr[i];
      mlfsr[i] = ((cur << 1) | (((cur >> 15) ^ (cur >> 13) ^ (cur >> 12) ^ (cur >> 10)) & 1)) & 32'hFFFF;
      case (mst[i])
        0: if (rr != 0) capture(i, cur);
        1: begin
          if (cyc == mdl[i]) mst[i] = 5;
          else if (rr != 0) capture(i, cur);
          else if (rs != 0) begin
            ment[i] = (ment[i] * 16 + int'(digit_in)) % (1 << (4 * dig(i)));
            mcnt[i]++;
            if (mcnt[i] == dig(i)) mst[i] = 2;
          end
        end
        2: begin
          mdl[i]++;
          if (ment[i] == motp[i]) begin
            mst[i] = 3; mwr[i] = 0; mend[i] = cyc + UNL;
          end else begin
            mwr[i]++;
            if (mwr[i] == MAXA) begin
              mst[i] = 4; mend[i] = cyc + LCK;
            end else begin
              mst[i] = 1; ment[i] = 0; mcnt[i] = 0;
            end
          end
        end
        3: if (cyc == mend[i]) begin mst[i] = 0; ment[i] = 0; mcnt[i] = 0; end
        4: if (cyc == mend[i]) begin mst[i] = 0; mwr[i] = 0; ment[i] = 0; mcnt[i] = 0; end
        5: if (rr != 0) capture(i, cur);
        default: mst[i] = 0;
      endcase
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] st, input logic [31:0] otp, input logic [31:0] ent,
                          input logic [31:0] cnt, input logic [31:0] wr, input logic [31:0] ul,
                          input logic [31:0] lk, input logic [31:0] ex);
    check($sformatf("state_%0d", i), st, 32'(mst[i]));
    check($sformatf("otp_%0d", i), otp, 32'(motp[i]));
    check($sformatf("entry_%0d", i), ent, 32'(ment[i]));
    check($sformatf("cnt_%0d", i), cnt, 32'(mcnt[i]));
    check($sformatf("wrng_%0d", i), wr, 32'(mwr[i]));
    check($sformatf("unlock_%0d", i), ul, 32'(mst[i] == 3));
    check($sformatf("lock_%0d", i), lk, 32'(mst[i] == 4));
    check($sformatf("expired_%0d", i), ex, 32'(mst[i] == 5));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    cmp_inst(0, 32'(a_st), 32'(a_otp), 32'(a_ent), 32'(a_cnt), 32'(a_wr), 32'(a_ul), 32'(a_lk), 32'(a_ex));
    cmp_inst(1, 32'(b_st), 32'(b_otp), 32'(b_ent), 32'(b_cnt), 32'(b_wr), 32'(b_ul), 32'(b_lk), 32'(b_ex));
  endtask

  task automatic press_req();
    otp_req = 1'b1; tick();
    otp_req = 1'b0; tick();
  endtask

  task automatic press_digit(input int d, input int hold);
    digit_in = 4'(d);
    digit_strobe = 1'b1;
    repeat (hold) tick();
    digit_strobe = 1'b0;
    tick();
  endtask

  task automatic enter_code(input int code);
    for (int k = 3; k >= 0; k--) press_digit((code >> (4 * k)) & 15, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (a_st != 3'd0 && n < 200) begin tick(); n++; end
    check(tag, 32'(a_st), 32'd0);
  endtask

  initial begin
    int n, c0, old_otp, nib;
    reset = 1'b1; otp_req = 1'b0; digit_strobe = 1'b0; digit_in = 4'h0;
    repeat (3) tick();
    check("reset_state", 32'(a_st), 32'd0);
    check("reset_otp", 32'(a_otp), 32'd0);
    reset = 1'b0;
    tick();
    otp_req = 1'b1; tick();
    check("b_lfsr_capture", 32'(b_otp), 32'h02);
    otp_req = 1'b0; tick();

    // Correct entry: CHECK for one cycle, then a timed unlock window.
    for (int k = 3; k >= 1; k--) press_digit((motp[0] >> (4 * k)) & 15, 1);
    digit_in = 4'(motp[0] & 15); digit_strobe = 1'b1; tick();
    check("check_state", 32'(a_st), 32'd2);
    digit_strobe = 1'b0; tick();
    n = 0;
    while (a_ul && n < 100) begin n++; tick(); end
    check("unlock_len", 32'(n), 32'(UNL));
    check("after_unlock", 32'(a_st), 32'd0);
    wait_idle("idle_1");

    // Three wrong attempts lead to a lockout that otp_req cannot shorten.
    for (int a = 0; a < MAXA; a++) begin
      press_req();
      enter_code(motp[0] ^ 1);
      if (a < MAXA - 1) check("wrng_step", 32'(a_wr), 32'(a + 1));
    end
    check("locked", 32'(a_lk), 32'd1);
    n = 0;
    while (a_lk && n < 100) begin
      if (n == 3) otp_req = 1'b1;
      if (n == 5) begin otp_req = 1'b0; check("lock_hold", 32'(a_st), 32'd4); end
      n++; tick();
    end
    check("lock_len", 32'(n), 32'(LCK));
    check("lock_wrng_clr", 32'(a_wr), 32'd0);
    wait_idle("idle_2");

    // Expiry with a partial entry.
    otp_req = 1'b1; tick(); c0 = cyc; otp_req = 1'b0;
    press_digit(1, 1); press_digit(2, 1);
    n = 0;
    while (!a_ex && n < 100) begin tick(); n++; end
    check("expire_time", 32'(cyc - c0), 32'(EXP));
    check("expire_cnt", 32'(a_cnt), 32'd2);
    press_req();
    check("reentry", 32'(a_st), 32'd1);

    // Wrong entry, then recapture mid-entry keeps the attempt count.
    enter_code(motp[0] ^ 16'h8000);
    check("wrng_one", 32'(a_wr), 32'd1);
    press_digit(3, 1);
    old_otp = motp[0];
    press_req();
    check("recap_otp_changed", 32'(a_otp != 16'(old_otp)), 32'd1);
    check("recap_cnt", 32'(a_cnt), 32'd0);
    check("recap_wrng", 32'(a_wr), 32'd1);
    enter_code(motp[0]);
    check("recap_unlock", 32'(a_ul), 32'd1);
    check("recap_wrng_clr", 32'(a_wr), 32'd0);
    wait_idle("idle_3");

    // Simultaneous request and digit: request wins, digit dropped.
    press_req();
    press_digit(7, 1);
    old_otp = motp[0];
    otp_req = 1'b1; digit_strobe = 1'b1; tick();
    check("simul_cnt", 32'(a_cnt), 32'd0);
    check("simul_otp", 32'(a_otp != 16'(old_otp)), 32'd1);
    otp_req = 1'b0; digit_strobe = 1'b0; tick();

    // Held strobe enters a single digit.
    press_digit(5, 10);
    check("held_strobe", 32'(a_cnt), 32'd1);

    // Final digit landing on the expiry edge.
    otp_req = 1'b1; tick(); c0 = cyc; otp_req = 1'b0; tick();
    for (int k = 0; k < 3; k++) press_digit(k, 1);
    while (cyc < c0 + EXP - 1) tick();
    digit_in = 4'h9; digit_strobe = 1'b1; tick();
    check("final_digit_exp", 32'(a_st), 32'd5);
    check("final_digit_cnt", 32'(a_cnt), 32'd3);
    digit_strobe = 1'b0; tick();

    // Reset mid-entry.
    press_req();
    press_digit(4, 1);
    reset = 1'b1; tick();
    check("rst_b_all", 32'({b_otp, b_ent, b_cnt, b_wr, b_ul, b_lk, b_ex, b_st}), 32'd0);
    check("rst_a_state", 32'(a_st), 32'd0);
    reset = 1'b0; tick();

    // Randomised phase, biased toward correct digits so unlocks occur.
    for (int t = 0; t < 4000; t++) begin
      reset = ($urandom_range(0, 999) == 0);
      otp_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) digit_strobe = ~digit_strobe;
      nib = 3 - mcnt[0];
      if (nib < 0) nib = 0;
      if ($urandom_range(0, 9) < 6) digit_in = 4'((motp[0] >> (4 * nib)) & 15);
      else digit_in = 4'($urandom_range(0, 15));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
